// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs field-level commands into 32-bit words and writes
// them to consecutive instruction-memory addresses. Define INSTR_ENCODER_JAL_EN to enable jal (in_sel 9).
module instr_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_sel,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [3:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    input  logic          in_last,
    output logic          imem_we,
    input  logic          imem_ready,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err_illegal,
    output logic          err_full,
    output logic [AW:0]   words
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] base;
    logic          last_taken;

    logic [5:0]    op;
    logic          legal;
    logic [31:0]   enc;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        op    = '0;
        legal = 1'b1;
        unique case (in_sel)
            4'd0:    op = 6'b101111;
            4'd1:    op = 6'b110000;
            4'd2:    op = 6'b110001;
            4'd3:    op = 6'b110010;
            4'd4:    op = 6'b110011;
            4'd5:    op = 6'b110100;
            4'd6:    op = 6'b110101;
            4'd7:    op = 6'b110110;
            4'd8:    op = 6'b110111;
`ifdef INSTR_ENCODER_JAL_EN
            4'd9:    op = 6'b111000;
`endif
            default: legal = 1'b0;
        endcase

        enc = {op, in_rs, in_rt, in_imm};
        if (in_sel == 4'd0)
            enc = {op, in_rs, in_rt, in_rd, in_shamt, 2'b00, in_funct};
        else if (in_sel == 4'd8 || in_sel == 4'd9)
            enc = {op, in_target};
    end

    logic        wr_done, accept, load, last_next, pend_next;
    logic [AW:0] words_next, in_flight;

    assign in_flight  = words + (AW+1)'(imem_we);
    assign in_ready   = (state == S_RUN) && !last_taken && (in_flight < DEPTH_C)
                        && (!imem_we || imem_ready);
    assign wr_done    = imem_we && imem_ready;
    // start wins over a simultaneous handshake: the command is dropped.
    assign accept     = in_valid && in_ready && !start;
    assign load       = accept && legal;
    assign last_next  = last_taken || (accept && in_last);
    assign pend_next  = load || (imem_we && !imem_ready);
    assign words_next = words + (AW+1)'(wr_done);

    assign imem_addr  = base + words[AW-1:0];
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            base        <= '0;
            words       <= '0;
            last_taken  <= 1'b0;
            imem_we     <= 1'b0;
            imem_wdata  <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else if (start) begin
            state       <= S_RUN;
            base        <= base_addr;
            words       <= '0;
            last_taken  <= 1'b0;
            imem_we     <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else if (state == S_RUN) begin
            if (load) begin
                imem_we    <= 1'b1;
                imem_wdata <= enc;
            end else if (wr_done) begin
                imem_we <= 1'b0;
            end
            words      <= words_next;
            last_taken <= last_next;
            if (accept && !legal)
                err_illegal <= 1'b1;
            // Session ends once the last command is consumed and nothing remains to write.
            if (last_next && !pend_next) begin
                state <= S_DONE;
            end else if (wr_done && words_next == DEPTH_C && !last_next) begin
                state    <= S_DONE;
                err_full <= 1'b1;
            end
        end
    end

endmodule
